// File: rtl/codec_i2c_pkg.sv
// codec_i2c_pkg
// Shared definitions for the I2C codec control-port responder:
//   - DEV_ADDR     : 7-bit target address that is ACKed
//   - REG_RST_IDX  : register index whose write clears the register file
//   - NUM_REGS     : register file depth
//   - DATA_W       : register value width
//   - state_t      : responder FSM state encoding
package codec_i2c_pkg;

    localparam logic [6:0] DEV_ADDR    = 7'h1A;
    localparam logic [3:0] REG_RST_IDX = 4'hF;
    localparam int         NUM_REGS    = 16;
    localparam int         DATA_W      = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_BYTE1,
        ST_ACK_1,
        ST_BYTE2,
        ST_ACK_2,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync
// Brings the asynchronous SCL/SDA pair into the i_clk domain and produces
// single-cycle event pulses.
//   i_clk, i_rst_n   : system clock, asynchronous active-low reset
//   i_scl, i_sda     : raw bus lines (asynchronous)
//   o_sda            : synchronized (optionally filtered) SDA level
//   o_start, o_stop  : START / STOP condition pulses
//   o_scl_rise/_fall : SCL edge pulses
// Optional macro I2C_GLITCH_FILTER_EN adds a 3-sample persistence filter
// after each synchronizer (+2 cycles of latency, rejects pulses < 3 cycles).
module i2c_line_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_start,
    output logic o_stop,
    output logic o_scl_rise,
    output logic o_scl_fall
);

    // [0] first flop, [1] synchronized value. Reset to 1 (idle bus) so that
    // leaving reset never fabricates an edge.
    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    // Last accepted level; also the filter's held output when filtering.
    logic       scl_prev_q;
    logic       sda_prev_q;
    logic       scl_cur;
    logic       sda_cur;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], i_scl};
            sda_sync_q <= {sda_sync_q[0], i_sda};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q;
    logic [1:0] sda_hist_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
        end
    end

    // A new level is accepted only once three consecutive samples agree.
    always_comb begin
        scl_cur = scl_prev_q;
        sda_cur = sda_prev_q;
        if (scl_sync_q[1] == scl_hist_q[0] && scl_hist_q[0] == scl_hist_q[1])
            scl_cur = scl_sync_q[1];
        if (sda_sync_q[1] == sda_hist_q[0] && sda_hist_q[0] == sda_hist_q[1])
            sda_cur = sda_sync_q[1];
    end
`else
    always_comb begin
        scl_cur = scl_sync_q[1];
        sda_cur = sda_sync_q[1];
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_cur;
            sda_prev_q <= sda_cur;
        end
    end

    // START/STOP need SCL high on both sides of the SDA transition.
    assign o_sda      = sda_cur;
    assign o_start    = scl_cur & scl_prev_q & sda_prev_q & ~sda_cur;
    assign o_stop     = scl_cur & scl_prev_q & ~sda_prev_q & sda_cur;
    assign o_scl_rise = scl_cur & ~scl_prev_q;
    assign o_scl_fall = ~scl_cur & scl_prev_q;

endmodule

// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder
// I2C write-only target emulating the audio codec control port. Each 3-byte
// write (address, {reg[6:0],data[8]}, data[7:0]) commits one 9-bit register.
//   i_clk, i_rst_n   : system clock (>= 8x SCL), async active-low reset
//   i_scl, i_sda     : bus lines (asynchronous)
//   o_sda_oe         : 1 = pull SDA low
//   o_reg_wr         : one-cycle commit strobe
//   o_reg_addr/data  : last committed address / value
//   o_busy           : high between START and STOP
//   o_nack           : one-cycle pulse per NACKed byte
//   i_rd_addr        : readback index; o_rd_data = regs[i_rd_addr] (1 cycle)
//   o_dbg_state      : current FSM state
// Optional macro I2C_GLITCH_FILTER_EN (forwarded to i2c_line_sync).
module i2c_codec_responder
    import codec_i2c_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_scl,
    input  logic              i_sda,
    output logic              o_sda_oe,
    output logic              o_reg_wr,
    output logic [6:0]        o_reg_addr,
    output logic [DATA_W-1:0] o_reg_data,
    output logic              o_busy,
    output logic              o_nack,
    input  logic [3:0]        i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output state_t            o_dbg_state
);

    logic sda_lvl, start_p, stop_p, scl_rise, scl_fall;

    i2c_line_sync u_line_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_scl      (i_scl),
        .i_sda      (i_sda),
        .o_sda      (sda_lvl),
        .o_start    (start_p),
        .o_stop     (stop_p),
        .o_scl_rise (scl_rise),
        .o_scl_fall (scl_fall)
    );

    state_t            state_q;
    logic [3:0]        bit_cnt_q;
    logic [7:0]        shift_q;
    logic [6:0]        addr_hold_q;
    logic              data8_q;
    logic              sda_oe_q;
    logic              busy_q;
    logic              nack_q;
    logic              reg_wr_q;
    logic [6:0]        reg_addr_q;
    logic [DATA_W-1:0] reg_data_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            addr_hold_q <= 7'd0;
            data8_q     <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            nack_q      <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_addr_q  <= 7'd0;
            reg_data_q  <= '0;
            rd_data_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            reg_wr_q  <= 1'b0;
            nack_q    <= 1'b0;
            rd_data_q <= regs_q[i_rd_addr];

            // Bus conditions outrank bit sampling in the same cycle.
            if (start_p) begin
                state_q   <= ST_ADDR;
                bit_cnt_q <= 4'd0;
                busy_q    <= 1'b1;
                sda_oe_q  <= 1'b0;
            end else if (stop_p) begin
                state_q   <= ST_IDLE;
                bit_cnt_q <= 4'd0;
                busy_q    <= 1'b0;
                sda_oe_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_ADDR, ST_BYTE1, ST_BYTE2: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[6:0], sda_lvl};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            bit_cnt_q <= 4'd0;
                            sda_oe_q  <= 1'b1;
                            if (state_q == ST_ADDR) begin
                                if (shift_q[7:1] == DEV_ADDR && !shift_q[0]) begin
                                    state_q <= ST_ACK_A;
                                end else begin
                                    // Not for us: leave SDA released and treat the
                                    // 9th clock as part of IGNORE's byte framing.
                                    sda_oe_q  <= 1'b0;
                                    nack_q    <= 1'b1;
                                    bit_cnt_q <= 4'd8;
                                    state_q   <= ST_IGNORE;
                                end
                            end else if (state_q == ST_BYTE1) begin
                                addr_hold_q <= shift_q[7:1];
                                data8_q     <= shift_q[0];
                                state_q     <= ST_ACK_1;
                            end else begin
                                state_q <= ST_ACK_2;
                            end
                        end
                    end
                    ST_ACK_A, ST_ACK_1, ST_ACK_2: begin
                        if (scl_fall) begin
                            sda_oe_q  <= 1'b0;
                            bit_cnt_q <= 4'd0;
                            if (state_q == ST_ACK_A) begin
                                state_q <= ST_BYTE1;
                            end else if (state_q == ST_ACK_1) begin
                                state_q <= ST_BYTE2;
                            end else begin
                                reg_wr_q   <= 1'b1;
                                reg_addr_q <= addr_hold_q;
                                reg_data_q <= {data8_q, shift_q};
                                if (addr_hold_q[3:0] == REG_RST_IDX) begin
                                    for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
                                end else begin
                                    regs_q[addr_hold_q[3:0]] <= {data8_q, shift_q};
                                end
                                state_q <= ST_IGNORE;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        // Count 9 clocks per byte; NACK at the end of bit 8.
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) nack_q <= 1'b1;
                            else if (bit_cnt_q == 4'd9) bit_cnt_q <= 4'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_sda_oe    = sda_oe_q;
    assign o_reg_wr    = reg_wr_q;
    assign o_reg_addr  = reg_addr_q;
    assign o_reg_data  = reg_data_q;
    assign o_busy      = busy_q;
    assign o_nack      = nack_q;
    assign o_rd_data   = rd_data_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: drives I2C write transactions as the bus
// master and checks ACKs, NACK pulses, commit strobes and register readback
// against a transaction-level model of the codec register file.
module tb_i2c_codec_responder;
    import codec_i2c_pkg::*;

    localparam int Q = 4;  // quarter SCL period in i_clk cycles (SCL = clk/16)

    logic       clk;
    logic       rst_n;
    logic       scl;
    logic       sda_drv;
    logic       sda_bus;
    logic       sda_oe;
    logic       reg_wr;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;
    logic       busy;
    logic       nack;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    state_t     dbg_state;

    int check_cnt = 0;
    int err_cnt   = 0;
    int wr_seen   = 0;
    int nack_seen = 0;

    // Expected commits: {addr[6:0], data[8:0]}
    logic [15:0] exp_q[$];
    logic [8:0]  model_regs[16];
    logic [3:0]  rd_last;

    // Open-drain bus: either side can pull low.
    assign sda_bus = sda_drv & ~sda_oe;

    i2c_codec_responder dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_scl       (scl),
        .i_sda       (sda_bus),
        .o_sda_oe    (sda_oe),
        .o_reg_wr    (reg_wr),
        .o_reg_addr  (reg_addr),
        .o_reg_data  (reg_data),
        .o_busy      (busy),
        .o_nack      (nack),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after a rising edge.
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // ---------------- I2C master driver ----------------
    task automatic i2c_start();
        sda_drv = 1'b1; wait_clks(Q);
        scl     = 1'b1; wait_clks(Q);
        sda_drv = 1'b0; wait_clks(Q);
        scl     = 1'b0; wait_clks(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_clks(Q);
        scl     = 1'b1; wait_clks(Q);
        sda_drv = 1'b1; wait_clks(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b; wait_clks(Q);
        scl     = 1'b1; wait_clks(2 * Q);
        scl     = 1'b0; wait_clks(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_drv = 1'b1; wait_clks(Q);
        scl     = 1'b1; wait_clks(Q);
        check({name, "_ack"}, {31'd0, ~sda_bus}, {31'd0, exp_ack});
        wait_clks(Q);
        scl     = 1'b0; wait_clks(Q);
        check({name, "_release"}, {31'd0, sda_oe}, 32'd0);
    endtask

    // Full write transaction; the expectation comes from the bus rules alone.
    task automatic write_txn(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input string name);
        logic addressed;
        int   n0;
        n0        = nack_seen;
        addressed = (b0[7:1] == 7'h1A) && !b0[0];
        if (addressed) exp_q.push_back({b1[7:1], b1[0], b2});
        i2c_start();
        check({name, "_busy_on"}, {31'd0, busy}, 32'd1);
        send_byte(b0, addressed, {name, "_b0"});
        send_byte(b1, addressed, {name, "_b1"});
        send_byte(b2, addressed, {name, "_b2"});
        i2c_stop();
        check({name, "_busy_off"}, {31'd0, busy}, 32'd0);
        check({name, "_nacks"}, nack_seen - n0, addressed ? 32'd0 : 32'd3);
    endtask

    task automatic read_reg(input logic [3:0] idx, input logic [8:0] exp, input string name);
        rd_addr = idx;
        wait_clks(2);
        check(name, {23'd0, rd_data}, {23'd0, exp});
    endtask

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) model_regs[i] = 9'd0;
            rd_last = rd_addr;
        end else begin
            check("rd_data", {23'd0, rd_data}, {23'd0, model_regs[rd_last]});
            if (reg_wr) begin
                logic [15:0] e;
                wr_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_wr", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", {25'd0, reg_addr}, {25'd0, e[15:9]});
                    check("wr_data", {23'd0, reg_data}, {23'd0, e[8:0]});
                    if (e[12:9] == 4'hF) begin
                        for (int i = 0; i < 16; i++) model_regs[i] = 9'd0;
                    end else begin
                        model_regs[e[12:9]] = e[8:0];
                    end
                end
            end
            if (nack) nack_seen++;
            rd_last = rd_addr;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int w0;
        rst_n   = 1'b0;
        scl     = 1'b1;
        sda_drv = 1'b1;
        rd_addr = 4'd0;
        wait_clks(3);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_reg_wr", {31'd0, reg_wr}, 32'd0);
        check("rst_busy",   {31'd0, busy},   32'd0);
        check("rst_nack",   {31'd0, nack},   32'd0);
        check("rst_addr",   {25'd0, reg_addr}, 32'd0);
        check("rst_data",   {23'd0, reg_data}, 32'd0);
        check("rst_rd",     {23'd0, rd_data},  32'd0);
        check("rst_state",  32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        wait_clks(4);

        // Basic write: reg 4 = 0x015
        w0 = wr_seen;
        write_txn(8'h34, 8'h08, 8'h15, "t1");
        check("t1_wr_count", wr_seen - w0, 32'd1);
        check("t1_addr_lit", {25'd0, reg_addr}, 32'h04);
        check("t1_data_lit", {23'd0, reg_data}, 32'h015);
        read_reg(4'd4, 9'h015, "t1_rd4");

        // data[8] set through BYTE1 bit 0: reg 9 = 0x1FF
        write_txn(8'h34, 8'h13, 8'hFF, "t2");
        check("t2_addr_lit", {25'd0, reg_addr}, 32'h09);
        check("t2_data_lit", {23'd0, reg_data}, 32'h1FF);
        read_reg(4'd9, 9'h1FF, "t2_rd9");

        // Wrong device address: no ACKs, 3 NACKs, no commit
        w0 = wr_seen;
        write_txn(8'h36, 8'h08, 8'h77, "t3");
        check("t3_wr_count", wr_seen - w0, 32'd0);
        read_reg(4'd4, 9'h015, "t3_rd4");

        // Read request to our address is refused too
        write_txn(8'h35, 8'h12, 8'h34, "t3r");

        // Upper address bits reported but ignored for storage: 0x7A -> reg 0xA
        write_txn(8'h34, 8'hF4, 8'h5A, "t3u");
        check("t3u_addr_lit", {25'd0, reg_addr}, 32'h7A);
        read_reg(4'hA, 9'h05A, "t3u_rdA");

        // Write to the clear index wipes the whole file
        write_txn(8'h34, 8'h1E, 8'h00, "t4");
        check("t4_addr_lit", {25'd0, reg_addr}, 32'h0F);
        for (int i = 0; i < 16; i++) read_reg(4'(i), 9'h000, "t4_rd_clear");

        // Repeated START after BYTE1 abandons the partial write
        w0 = wr_seen;
        i2c_start();
        send_byte(8'h34, 1'b1, "t5_a");
        send_byte(8'h08, 1'b1, "t5_b1");
        write_txn(8'h34, 8'h04, 8'hA0, "t5");
        check("t5_wr_count", wr_seen - w0, 32'd1);
        read_reg(4'd2, 9'h0A0, "t5_rd2");
        read_reg(4'd4, 9'h000, "t5_rd4");

        // Reset asserted while ACKing BYTE1
        i2c_start();
        send_byte(8'h34, 1'b1, "t6_a");
        for (int i = 7; i >= 0; i--) send_bit(1'b0);
        sda_drv = 1'b1; wait_clks(Q);
        scl     = 1'b1; wait_clks(Q);
        check("t6_oe_before", {31'd0, sda_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_oe_async", {31'd0, sda_oe}, 32'd0);
        wait_clks(2);
        scl = 1'b0;
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(4);
        check("t6_state", 32'(dbg_state), 32'(ST_IDLE));
        check("t6_busy", {31'd0, busy}, 32'd0);
        i2c_stop();
        check("t6_state_after_stop", 32'(dbg_state), 32'(ST_IDLE));
        read_reg(4'd2, 9'h000, "t6_rd2");

        wait_clks(4);
        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
